// File: rtl/sub_fixed.sv
// Registered sign-magnitude Q5.6 subtractor (diff = a - b) with overflow flag.
// Define SUB_FIXED_SAT_EN to saturate overflowing results instead of wrapping.
module sub_fixed #(
   parameter int WIDTH = 12,
   parameter int FRAC  = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] diff,
   output logic             overflow
);

   localparam int MW = WIDTH - 1;

   logic          sa, sb_eff;
   logic [MW-1:0] ma, mb;
   logic [MW:0]   sum;
   logic          res_sign;
   logic [MW-1:0] res_mag;
   logic          res_ovf;

   assign sa     = a[MW];
   assign sb_eff = ~b[MW];
   assign ma     = a[MW-1:0];
   assign mb     = b[MW-1:0];
   assign sum    = {1'b0, ma} + {1'b0, mb};

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      res_sign = sa;
      res_mag  = '0;
      res_ovf  = 1'b0;
      if (sa == sb_eff) begin
         res_ovf = sum[MW];
         if (sum[MW]) begin
`ifdef SUB_FIXED_SAT_EN
            res_mag = '1;
`else
            res_mag = sum[MW-1:0];
`endif
         end else begin
            res_mag = sum[MW-1:0];
         end
      end else if (ma >= mb) begin
         res_mag = ma - mb;
      end else begin
         res_sign = sb_eff;
         res_mag  = mb - ma;
      end
      // A zero magnitude is always +0; this also absorbs -0 operands.
      if (res_mag == '0) res_sign = 1'b0;
   end

   // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         diff      <= '0;
         overflow  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            diff     <= {res_sign, res_mag};
            overflow <= res_ovf;
         end
      end
   end

endmodule

// File: tb/tb_sub_fixed.sv
// Directed self-checking bench for sub_fixed; expectations follow SUB_FIXED_SAT_EN.
module tb_sub_fixed;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [11:0] a = '0;
   logic [11:0] b = '0;
   logic        out_valid;
   logic [11:0] diff;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   sub_fixed #(.WIDTH(12), .FRAC(6)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .a(a),
      .b(b),
      .out_valid(out_valid),
      .diff(diff),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Apply one operation at the falling edge, then sample 1 ns after the capturing edge.
   task automatic op(input logic [11:0] ia, input logic [11:0] ib);
      @(negedge clk);
      in_valid = 1'b1;
      a = ia;
      b = ib;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      a = 'x;
      b = 'x;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      op(12'h100, 12'h040);
      tests++;
      if (diff !== 12'h0C0 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset: diff=%h out_valid=%b, want 0c0/1", diff, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b1;
      a = 12'h7FF;
      b = 12'h801;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (diff !== 12'h000 || overflow !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: diff=%h ovf=%b vld=%b, want 000/0/0", diff, overflow, out_valid);
      end
      @(posedge clk);
      #1;
      tests++;
      if (diff !== 12'h000 || overflow !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold: diff=%h ovf=%b vld=%b, want 000/0/0", diff, overflow, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (diff !== 12'h000 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: diff=%h vld=%b, want 000/0", diff, out_valid);
      end
   endtask

   task automatic test_same_sign();
      op(12'h0A0, 12'h050);
      tests++;
      if (diff !== 12'h050 || overflow !== 1'b0 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL same_sign: diff=%h ovf=%b vld=%b, want 050/0/1", diff, overflow, out_valid);
      end
   endtask

   task automatic test_negative();
      op(12'h040, 12'h080);
      tests++;
      if (diff !== 12'h840 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL negative_result: diff=%h ovf=%b, want 840/0", diff, overflow);
      end
      op(12'h000, 12'h040);
      tests++;
      if (diff !== 12'h840 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL zero_minuend: diff=%h ovf=%b, want 840/0", diff, overflow);
      end
   endtask

   task automatic test_mixed_signs();
      op(12'h8C0, 12'h860);
      tests++;
      if (diff !== 12'h860 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL both_negative: diff=%h ovf=%b, want 860/0", diff, overflow);
      end
      op(12'h080, 12'h880);
      tests++;
      if (diff !== 12'h100 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL pos_minus_neg: diff=%h ovf=%b, want 100/0", diff, overflow);
      end
   endtask

   task automatic test_zero();
      op(12'h0C0, 12'h0C0);
      tests++;
      if (diff !== 12'h000 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL zero_result: diff=%h ovf=%b, want 000/0", diff, overflow);
      end
      op(12'h800, 12'h000);
      tests++;
      if (diff !== 12'h000 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL neg_zero: diff=%h ovf=%b, want 000/0", diff, overflow);
      end
   endtask

   task automatic test_overflow();
      logic [11:0] exp1, exp2, exp3;
`ifdef SUB_FIXED_SAT_EN
      exp1 = 12'h7FF;
      exp2 = 12'hFFF;
      exp3 = 12'hFFF;
`else
      exp1 = 12'h000;  // 0x7FF + 0x001 wraps to magnitude 0, encoded +0
      exp2 = 12'hFFE;  // -(0x7FF + 0x7FF) wraps to magnitude 0x7FE, sign kept
      exp3 = 12'h000;  // negative sum wrapping to magnitude 0 is still +0
`endif
      op(12'h7FF, 12'h801);
      tests++;
      if (diff !== exp1 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_pos: diff=%h ovf=%b, want %h/1", diff, overflow, exp1);
      end
      op(12'hFFF, 12'h7FF);
      tests++;
      if (diff !== exp2 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_neg: diff=%h ovf=%b, want %h/1", diff, overflow, exp2);
      end
      op(12'hFFF, 12'h001);
      tests++;
      if (diff !== exp3 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_neg_zero: diff=%h ovf=%b, want %h/1", diff, overflow, exp3);
      end
      op(12'h7C0, 12'h03F);
      tests++;
      if (diff !== 12'h781 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear: diff=%h ovf=%b, want 781/0", diff, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] va [3] = '{12'h100, 12'h040, 12'h200};
      logic [11:0] vb [3] = '{12'h040, 12'h100, 12'h8C0};
      logic [11:0] ve [3] = '{12'h0C0, 12'h8C0, 12'h2C0};
      for (int i = 0; i < 3; i++) begin
         op(va[i], vb[i]);
         tests++;
         if (diff !== ve[i] || out_valid !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_%0d: diff=%h vld=%b ovf=%b, want %h/1/0", i, diff, out_valid, overflow, ve[i]);
         end
      end
      idle();
      tests++;
      if (out_valid !== 1'b0 || diff !== 12'h2C0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL drop_valid: diff=%h vld=%b ovf=%b, want 2c0/0/0", diff, out_valid, overflow);
      end
      idle();
      tests++;
      if (out_valid !== 1'b0 || diff !== 12'h2C0) begin
         fails++;
         $display("FAIL hold_x_inputs: diff=%h vld=%b, want 2c0/0", diff, out_valid);
      end
   endtask

   initial begin
      #1;
      tests++;
      if (diff !== 12'h000 || overflow !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL initial_reset: diff=%h ovf=%b vld=%b, want 000/0/0", diff, overflow, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_same_sign();
      test_negative();
      test_mixed_signs();
      test_zero();
      test_overflow();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
